rng_stats_collector: RTL and testbench

Downstream monitor for the Gaussian RNG stage. It accepts one unsigned 18-bit sample per valid cycle over a window of 2^LOG2_N samples. Over that window it accumulates sum, sum of squares, min, max and a 16-bin histogram of the sample's top four bits. Results are held behind a valid/ready handshake so firmware or the bench can read them, and generator quality is checked in-system.

---
 rtl/rng_pkg.sv | 16 +
 rtl/rng_stats_collector_if.sv | 54 +++++
 rtl/rng_hist_bank.sv | 31 +++
 rtl/rng_stats_collector.sv | 142 ++++++++++++++
 tb/tb_rng_stats_collector.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rng_pkg.sv
// rng_pkg: shared sample width, window/histogram defaults and the
// state type used by the RNG statistics monitor.
package rng_pkg;

  localparam int SAMPLE_W   = 18;
  localparam int WIN_LOG2_N = 10;
  localparam int HIST_HB    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/rng_stats_collector_if.sv
// rng_stats_collector_if: sample stream in, result handshake out.
// master = producer/consumer side, slave = the stats collector.
interface rng_stats_collector_if
  import rng_pkg::*;
#(
  parameter int W      = SAMPLE_W,
  parameter int LOG2_N = WIN_LOG2_N,
  parameter int HB     = HIST_HB
);

  logic                  start;
  logic                  sample_valid;
  logic [W-1:0]          sample;
  logic                  busy;
  logic                  res_valid;
  logic                  res_ready;
  logic [W+LOG2_N-1:0]   sum;
  logic [2*W+LOG2_N-1:0] sumsq;
  logic [W-1:0]          min_s;
  logic [W-1:0]          max_s;
  logic [HB-1:0]         hist_addr;
  logic [LOG2_N:0]       hist_data;

  modport master (
    output start,
    output sample_valid,
    output sample,
    output res_ready,
    output hist_addr,
    input  busy,
    input  res_valid,
    input  sum,
    input  sumsq,
    input  min_s,
    input  max_s,
    input  hist_data
  );

  modport slave (
    input  start,
    input  sample_valid,
    input  sample,
    input  res_ready,
    input  hist_addr,
    output busy,
    output res_valid,
    output sum,
    output sumsq,
    output min_s,
    output max_s,
    output hist_data
  );

endinterface

// File: rtl/rng_hist_bank.sv
// rng_hist_bank: 2^HB counters, sync clear, one increment port
// (inc, idx) and a combinational read port (addr -> data).
module rng_hist_bank #(
  parameter int HB = 4,
  parameter int CW = 11
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          inc,
  input  logic [HB-1:0] idx,
  input  logic [HB-1:0] addr,
  output logic [CW-1:0] data
);

  localparam int NB = 1 << HB;

  logic [CW-1:0] cnt [NB];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NB; i++) begin
        cnt[i] <= '0;
      end
    end else if (inc) begin
      cnt[idx] <= cnt[idx] + CW'(1);
    end
  end

  assign data = cnt[addr];

endmodule

// File: rtl/rng_stats_collector.sv
// rng_stats_collector: windowed sum/sumsq/min/max/histogram of RNG
// samples. Ports: clk, reset (sync, active-low), bus (slave).
module rng_stats_collector
  import rng_pkg::*;
#(
  parameter int W      = SAMPLE_W,
  parameter int LOG2_N = WIN_LOG2_N,
  parameter int HB     = HIST_HB
) (
  input  logic                clk,
  input  logic                reset,
  rng_stats_collector_if.slave bus
);

  localparam int SW = W + LOG2_N;
  localparam int QW = 2 * W + LOG2_N;
  localparam int CW = LOG2_N + 1;

  localparam logic [LOG2_N:0] LAST =
    {1'b0, {LOG2_N{1'b1}}};

  state_e          state;
  logic [LOG2_N:0] cnt;
  logic            drain;
  logic            take;
  logic            clr;

  logic            s1_v;
  logic [W-1:0]    s1_d;

  logic [2*W-1:0]  sq;
  logic [HB-1:0]   bin;

  logic [SW-1:0]   sum_q;
  logic [QW-1:0]   sumsq_q;
  logic [W-1:0]    min_q;
  logic [W-1:0]    max_q;

  // cnt MSB set means the window is full
  assign take = (state == ACCUM)
              && bus.sample_valid
              && !cnt[LOG2_N];

  assign clr = (state == IDLE) && bus.start;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      drain <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            cnt   <= '0;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (take) begin
            cnt <= cnt + CW'(1);
            if (cnt == LAST) begin
              drain <= 1'b0;
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          drain <= 1'b1;
          if (drain) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_v <= 1'b0;
      s1_d <= '0;
    end else begin
      s1_v <= take;
      if (take) begin
        s1_d <= bus.sample;
      end
    end
  end

  assign sq  = {{W{1'b0}}, s1_d}
             * {{W{1'b0}}, s1_d};
  assign bin = s1_d[W-1 -: HB];

  // the last sample drains out of stage 1
  // during DRAIN, before DONE is entered
  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      sum_q   <= '0;
      sumsq_q <= '0;
      min_q   <= '1;
      max_q   <= '0;
    end else if (s1_v) begin
      sum_q   <= sum_q
               + {{LOG2_N{1'b0}}, s1_d};
      sumsq_q <= sumsq_q
               + {{LOG2_N{1'b0}}, sq};
      if (s1_d < min_q) begin
        min_q <= s1_d;
      end
      if (s1_d > max_q) begin
        max_q <= s1_d;
      end
    end
  end

  rng_hist_bank #(
    .HB (HB),
    .CW (CW)
  ) u_hist (
    .clk  (clk),
    .clr  (!reset || clr),
    .inc  (s1_v),
    .idx  (bin),
    .addr (bus.hist_addr),
    .data (bus.hist_data)
  );

  assign bus.busy      = (state == ACCUM)
                      || (state == DRAIN);
  assign bus.res_valid = (state == DONE);
  assign bus.sum       = sum_q;
  assign bus.sumsq     = sumsq_q;
  assign bus.min_s     = min_q;
  assign bus.max_s     = max_q;

endmodule

// File: tb/tb_rng_stats_collector.sv
// tb_rng_stats_collector: directed checks on a 4-sample window DUT
// and a 1024-sample window DUT fed by a reference-modelled stream.
module tb_rng_stats_collector;

  logic clk = 1'b0;
  logic rst2 = 1'b0;
  logic rst10 = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rng_stats_collector_if #(
    .W(18), .LOG2_N(2), .HB(4)
  ) b2 ();

  rng_stats_collector_if #(
    .W(18), .LOG2_N(10), .HB(4)
  ) b10 ();

  rng_stats_collector #(
    .W(18), .LOG2_N(2), .HB(4)
  ) u2 (
    .clk   (clk),
    .reset (rst2),
    .bus   (b2)
  );

  rng_stats_collector #(
    .W(18), .LOG2_N(10), .HB(4)
  ) u10 (
    .clk   (clk),
    .reset (rst10),
    .bus   (b10)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic feed2(input logic [17:0] v);
    b2.sample = v;
    b2.sample_valid = 1'b1;
    step();
    b2.sample_valid = 1'b0;
  endtask

  task automatic feed10(input logic [17:0] v);
    b10.sample = v;
    b10.sample_valid = 1'b1;
    step();
    b10.sample_valid = 1'b0;
  endtask

  task automatic wait_rv2(input string tag);
    int n = 0;
    while (b2.res_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk(tag, 64'(n), 64'd2);
  endtask

  task automatic wait_rv10(input string tag);
    int n = 0;
    while (b10.res_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk(tag, 64'(n), 64'd2);
  endtask

  task automatic hist2(input string tag,
                       input int bin,
                       input int exp);
    b2.hist_addr = 4'(bin);
    #1;
    chk($sformatf("%s[%0d]", tag, bin),
        64'(b2.hist_data), 64'(exp));
  endtask

  task automatic start2();
    b2.start = 1'b1;
    step();
    b2.start = 1'b0;
  endtask

  logic [17:0] t2v [4];
  logic [63:0] v;
  logic [63:0] rsum;
  logic [63:0] rsq;
  logic [17:0] rmin;
  logic [17:0] rmax;
  int          eh [16];
  int          tot;

  initial begin
    b2.start = 1'b0;
    b2.sample_valid = 1'b0;
    b2.sample = '0;
    b2.res_ready = 1'b0;
    b2.hist_addr = '0;
    b10.start = 1'b0;
    b10.sample_valid = 1'b0;
    b10.sample = '0;
    b10.res_ready = 1'b0;
    b10.hist_addr = '0;
    t2v[0] = 18'h00000;
    t2v[1] = 18'h3FFFF;
    t2v[2] = 18'h10000;
    t2v[3] = 18'h3FFFF;

    step();
    step();
    chk("rst_busy", 64'(b2.busy), 64'd0);
    chk("rst_rv", 64'(b2.res_valid), 64'd0);
    chk("rst_sum", 64'(b2.sum), 64'd0);
    chk("rst_sumsq", 64'(b2.sumsq), 64'd0);
    chk("rst_min", 64'(b2.min_s), 64'h3FFFF);
    chk("rst_max", 64'(b2.max_s), 64'd0);
    hist2("rst_hist", 0, 0);
    hist2("rst_hist", 15, 0);
    rst2 = 1'b1;
    rst10 = 1'b1;
    step();

    // four equal samples, then extra samples in DRAIN
    start2();
    chk("t1_busy", 64'(b2.busy), 64'd1);
    for (int i = 0; i < 4; i++) begin
      b2.sample = 18'h20000;
      b2.sample_valid = 1'b1;
      step();
    end
    chk("t1_drain", 64'(b2.busy), 64'd1);
    b2.sample = 18'h3FFFF;
    wait_rv2("t1_lat");
    b2.sample_valid = 1'b0;
    chk("t1_busy_done", 64'(b2.busy), 64'd0);
    chk("t1_sum", 64'(b2.sum), 64'h80000);
    chk("t1_sumsq", 64'(b2.sumsq), 64'h10_0000_0000);
    chk("t1_min", 64'(b2.min_s), 64'h20000);
    chk("t1_max", 64'(b2.max_s), 64'h20000);
    for (int b = 0; b < 16; b++) begin
      hist2("t1_hist", b, (b == 8) ? 4 : 0);
    end
    b2.res_ready = 1'b1;
    step();
    b2.res_ready = 1'b0;
    chk("t1_idle_rv", 64'(b2.res_valid), 64'd0);
    chk("t1_idle_busy", 64'(b2.busy), 64'd0);
    chk("t1_held_sum", 64'(b2.sum), 64'h80000);

    // extremes with random valid gaps
    start2();
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 5)) step();
      feed2(t2v[i]);
    end
    wait_rv2("t2_lat");
    chk("t2_sum", 64'(b2.sum), 64'h8FFFE);
    chk("t2_sumsq", 64'(b2.sumsq),
        64'd2 * 64'd262143 * 64'd262143
        + 64'h1_0000_0000);
    chk("t2_min", 64'(b2.min_s), 64'd0);
    chk("t2_max", 64'(b2.max_s), 64'h3FFFF);
    for (int b = 0; b < 16; b++) begin
      hist2("t2_hist", b,
            (b == 0 || b == 4) ? 1 :
            (b == 15) ? 2 : 0);
    end

    // held results while res_ready stays low
    for (int i = 0; i < 10; i++) begin
      b2.start = i[0];
      b2.sample = 18'h00005;
      b2.sample_valid = 1'b1;
      step();
      chk("t3_rv", 64'(b2.res_valid), 64'd1);
      chk("t3_busy", 64'(b2.busy), 64'd0);
      chk("t3_sum", 64'(b2.sum), 64'h8FFFE);
      chk("t3_min", 64'(b2.min_s), 64'd0);
      chk("t3_max", 64'(b2.max_s), 64'h3FFFF);
    end
    b2.sample_valid = 1'b0;
    hist2("t3_hist", 0, 1);
    b2.start = 1'b1;
    b2.res_ready = 1'b1;
    step();
    b2.start = 1'b0;
    b2.res_ready = 1'b0;
    chk("t3_hs_rv", 64'(b2.res_valid), 64'd0);
    chk("t3_hs_busy", 64'(b2.busy), 64'd0);
    step();
    chk("t3_no_start", 64'(b2.busy), 64'd0);
    chk("t3_held_sum", 64'(b2.sum), 64'h8FFFE);

    // reset mid-window, then a clean window
    start2();
    feed2(18'h3FFFF);
    feed2(18'h3FFFF);
    rst2 = 1'b0;
    step();
    rst2 = 1'b1;
    chk("t4_rst_busy", 64'(b2.busy), 64'd0);
    chk("t4_rst_sum", 64'(b2.sum), 64'd0);
    chk("t4_rst_min", 64'(b2.min_s), 64'h3FFFF);
    step();
    chk("t4_rst_idle", 64'(b2.busy), 64'd0);
    start2();
    for (int i = 0; i < 4; i++) begin
      feed2(18'h00001);
    end
    wait_rv2("t4_lat");
    chk("t4_sum", 64'(b2.sum), 64'd4);
    chk("t4_sumsq", 64'(b2.sumsq), 64'd4);
    chk("t4_min", 64'(b2.min_s), 64'd1);
    chk("t4_max", 64'(b2.max_s), 64'd1);
    hist2("t4_hist", 0, 4);
    hist2("t4_hist", 15, 0);
    b2.res_ready = 1'b1;
    step();
    b2.res_ready = 1'b0;

    // 1024-sample window against a reference model
    rsum = '0;
    rsq = '0;
    rmin = 18'h3FFFF;
    rmax = '0;
    for (int b = 0; b < 16; b++) eh[b] = 0;
    b10.start = 1'b1;
    step();
    b10.start = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      if ($urandom_range(0, 7) == 0) step();
      v = 64'($urandom_range(0, 262143));
      rsum = rsum + v;
      rsq = rsq + v * v;
      if (v[17:0] < rmin) rmin = v[17:0];
      if (v[17:0] > rmax) rmax = v[17:0];
      eh[v[17:14]]++;
      feed10(v[17:0]);
    end
    wait_rv10("t5_lat");
    chk("t5_sum", 64'(b10.sum), rsum);
    chk("t5_sumsq", 64'(b10.sumsq), rsq);
    chk("t5_min", 64'(b10.min_s), 64'(rmin));
    chk("t5_max", 64'(b10.max_s), 64'(rmax));
    tot = 0;
    for (int b = 0; b < 16; b++) begin
      b10.hist_addr = 4'(b);
      #1;
      tot = tot + int'(b10.hist_data);
      chk($sformatf("t5_hist[%0d]", b),
          64'(b10.hist_data), 64'(eh[b]));
    end
    chk("t5_hist_total", 64'(tot), 64'd1024);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
